// File: rtl/dwa_element_selector.sv
// dwa_element_selector
//   Quantizes the wide signed noise-shaper output to a unit-element code
//   0..NUM_ELEMENTS and applies data-weighted-averaging rotation to drive
//   the unit-element DAC array. Two-stage valid/ready pipeline.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   data_i       signed filter output sample
//   valid_i      data_i is valid
//   ready_o      block accepts data_i this cycle (combinational from ready_i)
//   sel_o        element enable mask, bit k drives element k
//   code_o       number of enabled elements (popcount of sel_o)
//   ptr_o        DWA start pointer used for the presented word
//   sat_o        presented word was clamped
//   valid_o      sel_o/code_o/ptr_o/sat_o are valid
//   ready_i      downstream accepts the output word
//   sat_count_o  count of accepted saturated words, sticks at 0xFFFF
module dwa_element_selector #(
    parameter int IN_WIDTH     = 64,
    parameter int NUM_ELEMENTS = 16,
    parameter int SHIFT        = 12,
    localparam int PTR_W       = $clog2(NUM_ELEMENTS),
    localparam int CODE_W      = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic signed [IN_WIDTH-1:0] data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [NUM_ELEMENTS-1:0]    sel_o,
    output logic [CODE_W-1:0]          code_o,
    output logic [PTR_W-1:0]           ptr_o,
    output logic                       sat_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [15:0]                sat_count_o
);

    // Stage 1: quantized code
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic              s1_sat;

    // DWA rotation pointer
    logic [PTR_W-1:0]  ptr;

    logic in_xfer;
    logic s1_adv;

    logic signed [IN_WIDTH-1:0] q;
    logic signed [IN_WIDTH:0]   c;
    logic [CODE_W-1:0]          code_n;
    logic                       sat_n;

    logic [NUM_ELEMENTS-1:0]    therm;
    logic [2*NUM_ELEMENTS-1:0]  rot;
    logic [NUM_ELEMENTS-1:0]    sel_n;

    assign s1_adv  = s1_valid && (!valid_o || ready_i);
    assign ready_o = !s1_valid || s1_adv;
    assign in_xfer = valid_i && ready_o;

    // Quantize: shift, re-centre around NUM_ELEMENTS/2, clamp.
    // The offset add is one bit wider than the input so it cannot wrap.
    always_comb begin
        q      = data_i >>> SHIFT;
        c      = {q[IN_WIDTH-1], q} + (IN_WIDTH+1)'(NUM_ELEMENTS / 2);
        code_n = c[CODE_W-1:0];
        sat_n  = 1'b0;
        if (c[IN_WIDTH]) begin
            code_n = '0;
            sat_n  = 1'b1;
        end else if (c > (IN_WIDTH+1)'(NUM_ELEMENTS)) begin
            code_n = CODE_W'(NUM_ELEMENTS);
            sat_n  = 1'b1;
        end
    end

    // Rotate: thermometer of s1_code, rotated left by ptr. Doubling the
    // thermometer and taking the upper half of the shift gives the wrap.
    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            therm[i] = (i < 32'(s1_code));
        end
        rot   = {therm, therm} << ptr;
        sel_n = rot[2*NUM_ELEMENTS-1:NUM_ELEMENTS];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_sat      <= 1'b0;
            sat_count_o <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_code  <= code_n;
                s1_sat   <= sat_n;
                if (sat_n && (sat_count_o != '1)) begin
                    sat_count_o <= sat_count_o + 16'd1;
                end
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Pointer advances only on a stage-2 load, so its sequence follows
    // acceptance order regardless of stalls. A full-scale code has zero
    // low bits and leaves the pointer where it was.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            sel_o   <= '0;
            code_o  <= '0;
            ptr_o   <= '0;
            sat_o   <= 1'b0;
            ptr     <= '0;
        end else begin
            if (s1_adv) begin
                valid_o <= 1'b1;
                sel_o   <= sel_n;
                code_o  <= s1_code;
                ptr_o   <= ptr;
                sat_o   <= s1_sat;
                ptr     <= ptr + s1_code[PTR_W-1:0];
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
